// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the execute-stage control blocks.
//   ALU_OP_ADD / ALU_OP_PASSA : ALU operation encodings the multiply
//                               sequencer drives onto the shared ALU.
//   seq_state_t               : multiply sequencer FSM states.
//   FLAG_N/Z/C/V              : bit positions inside a 4-bit {N,Z,C,V} word.
//   make_nzcv()               : packs the flag word for a 32-bit result.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] ALU_OP_ADD   = 4'b0100;
    localparam logic [3:0] ALU_OP_PASSA = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } seq_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // N and Z come from the value; C and V are carried through unchanged,
    // because a multiply leaves them architecturally untouched.
    function automatic logic [3:0] make_nzcv(input logic [31:0] value,
                                             input logic        c,
                                             input logic        v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = value[31];
        f[FLAG_Z] = (value == 32'd0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// ----------------------------------------------------------------------------
// alu_mul_sequencer
// Multi-cycle controller for ARM MUL/MLA. It borrows the shared 32-bit ALU
// and computes the low word of Rm*Rs (+Rn) with one shift-add step per
// multiplier bit.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   start                   operation request, sampled only in IDLE
//   accumulate              1 = MLA (start from acc_val), 0 = MUL
//   set_flags               S bit; gates nzcv_we at completion
//   rm_val, rs_val, acc_val multiplicand, multiplier, accumulator
//   cf_in, vf_in            current C/V flags, latched at start
//   alu_f                   result from the shared ALU
//   alu_op, alu_a, alu_b    ALU request (PASSA/0/0 outside ITER)
//   busy                    sequencer owns the ALU mux (start accepted .. done)
//   done                    one-cycle completion pulse
//   result, nzcv            product and its flags, valid from done
//   nzcv_we                 done & latched set_flags
//
// Configuration
//   MUL_EARLY_TERM_EN : when defined, iteration stops as soon as the
//   remaining multiplier bits are all zero, and rs_val == 0 completes
//   straight from IDLE. Undefined: fixed 33-cycle latency.
// ----------------------------------------------------------------------------
module alu_mul_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] rm_val,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] acc_val,
    input  logic             cf_in,
    input  logic             vf_in,
    input  logic [WIDTH-1:0] alu_f,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv,
    output logic             nzcv_we
);

    seq_state_t       state;
    logic [WIDTH-1:0] p;      // partial product
    logic [WIDTH-1:0] mc;     // multiplicand, shifted left each step
    logic [WIDTH-1:0] mr;     // multiplier, shifted right each step
    logic [CNT_W-1:0] cnt;
    logic             sf_q;
    logic             cf_q;
    logic             vf_q;
    logic             last_iter;

    always_comb begin
        last_iter = (cnt == CNT_W'(WIDTH - 1));
`ifdef MUL_EARLY_TERM_EN
        if ((mr >> 1) == '0) begin
            last_iter = 1'b1;
        end
`endif
    end

    // The ALU outputs are registered alongside p/mc/mr so that during ITER
    // alu_a always equals p and alu_b equals mc; the ALU therefore returns
    // the next partial product in the same cycle it is requested.
    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values of each other; blocking writes would make the shift
    // and the ALU request see half-updated state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            p       <= '0;
            mc      <= '0;
            mr      <= '0;
            cnt     <= '0;
            sf_q    <= 1'b0;
            cf_q    <= 1'b0;
            vf_q    <= 1'b0;
            alu_op  <= ALU_OP_PASSA;
            alu_a   <= '0;
            alu_b   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            nzcv    <= '0;
            nzcv_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    nzcv_we <= 1'b0;
                    if (start) begin
                        p    <= accumulate ? acc_val : '0;
                        mc   <= rm_val;
                        mr   <= rs_val;
                        cnt  <= '0;
                        sf_q <= set_flags;
                        cf_q <= cf_in;
                        vf_q <= vf_in;
                        busy <= 1'b1;
`ifdef MUL_EARLY_TERM_EN
                        if (rs_val == '0) begin
                            // Nothing to add: the answer is the start value.
                            state   <= DONE;
                            done    <= 1'b1;
                            nzcv_we <= set_flags;
                            result  <= accumulate ? acc_val : '0;
                            nzcv    <= make_nzcv(accumulate ? acc_val : '0,
                                                 cf_in, vf_in);
                        end else
`endif
                        begin
                            state  <= ITER;
                            alu_a  <= accumulate ? acc_val : '0;
                            alu_b  <= rm_val;
                            alu_op <= rs_val[0] ? ALU_OP_ADD : ALU_OP_PASSA;
                        end
                    end
                end

                ITER: begin
                    p   <= alu_f;
                    mc  <= mc << 1;
                    mr  <= mr >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        nzcv_we <= sf_q;
                        result  <= alu_f;
                        nzcv    <= make_nzcv(alu_f, cf_q, vf_q);
                        alu_op  <= ALU_OP_PASSA;
                        alu_a   <= '0;
                        alu_b   <= '0;
                    end else begin
                        // mr[1] is the multiplier bit that becomes MR[0]
                        // for the next step.
                        alu_a  <= alu_f;
                        alu_b  <= mc << 1;
                        alu_op <= mr[1] ? ALU_OP_ADD : ALU_OP_PASSA;
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    nzcv_we <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Directed and randomized bench for alu_mul_sequencer. A behavioural ALU
// closes the loop; expected products come from plain 32-bit multiplication.
// Expected latency follows MUL_EARLY_TERM_EN when the bench is built with it.
// ----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        accumulate;
    logic        set_flags;
    logic [31:0] rm_val;
    logic [31:0] rs_val;
    logic [31:0] acc_val;
    logic        cf_in;
    logic        vf_in;
    logic [31:0] alu_f;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  nzcv;
    logic        nzcv_we;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Behavioural shared ALU: ADD or pass A.
    assign alu_f = (alu_op == 4'b0100) ? alu_a + alu_b : alu_a;

    alu_mul_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .accumulate (accumulate),
        .set_flags  (set_flags),
        .rm_val     (rm_val),
        .rs_val     (rs_val),
        .acc_val    (acc_val),
        .cf_in      (cf_in),
        .vf_in      (vf_in),
        .alu_f      (alu_f),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .nzcv       (nzcv),
        .nzcv_we    (nzcv_we)
    );

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // Cycle (counted from the accepting edge) in which done is expected.
    function automatic int expected_latency(input logic [31:0] rs);
        int msb;
`ifdef MUL_EARLY_TERM_EN
        if (rs == 32'd0) return 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (rs[i]) msb = i;
        return msb + 2;
`else
        msb = 0;
        return 33 + msb;
`endif
    endfunction

    task automatic scramble_inputs();
        rm_val     = $urandom;
        rs_val     = $urandom;
        acc_val    = $urandom;
        accumulate = 1'($urandom);
        set_flags  = 1'($urandom);
        cf_in      = 1'($urandom);
        vf_in      = 1'($urandom);
    endtask

    // One operation: idle checks, start, then wait (bounded) for done.
    // glitch > 0 raises start again during that cycle of the operation.
    task automatic do_op(input string tag, input logic [31:0] rm,
                         input logic [31:0] rs, input logic [31:0] acc,
                         input logic accum, input logic sf, input logic cf,
                         input logic vf, input int glitch);
        logic [31:0] exp_p;
        logic [3:0]  exp_f;
        int          lat;
        int          exp_lat;
        logic [31:0] got_res;
        logic [3:0]  got_f;
        logic        got_we;

        exp_p   = rm * rs + (accum ? acc : 32'd0);
        exp_f   = {exp_p[31], exp_p == 32'd0, cf, vf};
        exp_lat = expected_latency(rs);
        lat     = -1;
        got_res = 'x;
        got_f   = 'x;
        got_we  = 1'bx;

        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " idle alu"}, {alu_op, alu_a[27:0] | alu_b[27:0]},
              {4'b1000, 28'd0});
        check({tag, " idle ab"}, alu_a | alu_b, 32'd0);
        rm_val = rm; rs_val = rs; acc_val = acc; accumulate = accum;
        set_flags = sf; cf_in = cf; vf_in = vf; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();

        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == glitch);
            if (c == 1 && exp_lat > 1) check({tag, " busy"}, 32'(busy), 32'd1);
            if (done) begin
                lat     = c;
                got_res = result;
                got_f   = nzcv;
                got_we  = nzcv_we;
                break;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, got_res, exp_p);
        check({tag, " nzcv"}, 32'(got_f), 32'(exp_f));
        check({tag, " nzcv_we"}, 32'(got_we), 32'(sf));
    endtask

    initial begin
        int          done_seen;
        int          we_seen;
        logic [31:0] r_rm, r_rs, r_acc;

        rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; set_flags = 1'b0;
        rm_val = '0; rs_val = '0; acc_val = '0; cf_in = 1'b0; vf_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset we", 32'(nzcv_we), 32'd0);
        check("reset result", result, 32'd0);
        check("reset nzcv", 32'(nzcv), 32'd0);
        check("reset alu_op", 32'(alu_op), 32'h8);
        check("reset alu_ab", alu_a | alu_b, 32'd0);
        rst_n = 1'b1;

        // Directed operations.
        do_op("mul3x5", 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_op("mla_wrap", 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        do_op("mul_zero", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1,
              1'b0, 1'b1, 0);
        // Back-to-back: starts in the cycle right after the previous done.
        do_op("b2b", 32'h1234_5678, 32'h8000_0001, 32'h0F0F_0F0F, 1'b1, 1'b1,
              1'b0, 1'b0, 0);
        // Start pulsed mid-operation is ignored.
        do_op("glitch", 32'd11, 32'h4000_0003, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        @(negedge clk);
        check("glitch single done", 32'(done), 32'd0);
        // Zero / unit multipliers (early-exit cases when enabled).
        do_op("rs0_mla", 32'hDEAD_BEEF, 32'd0, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        do_op("rs1", 32'd9, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_op("signed", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1,
              1'b0, 1'b1, 0);

        // Randomized operations.
        for (int i = 0; i < 8; i++) begin
            r_rm  = $urandom;
            r_rs  = (i % 3 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            r_acc = $urandom;
            do_op($sformatf("rand%0d", i), r_rm, r_rs, r_acc, 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        // Reset during an operation: no completion must follow.
        @(negedge clk);
        rm_val = 32'd5; rs_val = 32'hFFFF_FFFF; acc_val = 32'd3;
        accumulate = 1'b1; set_flags = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_seen = 0;
        we_seen   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (nzcv_we) we_seen++;
            if (c == 10) rst_n = 1'b0;
            if (c == 11) begin
                check("midreset busy", 32'(busy), 32'd0);
                check("midreset result", result, 32'd0);
                check("midreset alu", {28'd0, alu_op} | alu_a | alu_b, 32'h8);
                rst_n = 1'b1;
            end
        end
        check("midreset no done", 32'(done_seen), 32'd0);
        check("midreset no we", 32'(we_seen), 32'd0);

        // Sequencer is usable again after the abort.
        do_op("after_rst", 32'd100, 32'd250, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
